// File: rtl/share_serial_collector_if.sv
// Share-in / frame-out handshake bundle for the serial share collector.
// slave = collector view, master = upstream/downstream environment view.
interface share_serial_collector_if #(
    parameter int WIDTH   = 8,
    parameter int NSHARES = 3,
    parameter int IDXW    = $clog2(NSHARES)
);
    logic                     in_valid;
    logic                     in_first;
    logic [WIDTH-1:0]         in_share;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [NSHARES*WIDTH-1:0] out_shares;
    logic [IDXW-1:0]          share_idx;
    logic                     sync_err;

    modport slave (
        input  in_valid, in_first, in_share, out_ready,
        output in_ready, out_valid, out_shares, share_idx, sync_err
    );

    modport master (
        output in_valid, in_first, in_share, out_ready,
        input  in_ready, out_valid, out_shares, share_idx, sync_err
    );
endinterface

// File: rtl/share_serial_collector.sv
// Assembles NSHARES serial shares into one registered frame; out_valid rises 1 cycle after the last share.
// While a frame is held, in_ready follows out_ready so a new share only enters as the frame leaves.
module share_serial_collector #(
    parameter int WIDTH           = 8,
    parameter int NSHARES         = 3,
    parameter bit ZERO_ON_CONSUME = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    share_serial_collector_if.slave bus
);
    localparam int IDXW = $clog2(NSHARES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSHARES - 1);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

    state_e                         state_q, state_d;
    logic [NSHARES-1:0][WIDTH-1:0]  slots_q, slots_d;
    logic [IDXW-1:0]                idx_q, idx_d;
    logic                           sync_err_q, sync_err_d;
    logic                           in_ready;
    logic                           accept;
    logic                           consume;

    assign in_ready = (state_q == COLLECT) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign consume  = (state_q == HOLD) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            slots_q    <= '0;
            idx_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slots_q    <= slots_d;
            idx_q      <= idx_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slots_d    = slots_q;
        idx_d      = idx_q;
        sync_err_d = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    // A share-0 marker mid-frame means upstream lost alignment: restart here.
                    if (bus.in_first && (idx_q != '0)) begin
                        if (ZERO_ON_CONSUME) begin
                            slots_d = '0;
                        end
                        slots_d[0] = bus.in_share;
                        idx_d      = IDXW'(1);
                        sync_err_d = 1'b1;
                    end else begin
                        slots_d[idx_q] = bus.in_share;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = HOLD;
                        end else begin
                            idx_d = idx_q + IDXW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (consume) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                    if (ZERO_ON_CONSUME) begin
                        slots_d = '0;
                    end
                    if (accept) begin
                        slots_d[0] = bus.in_share;
                        idx_d      = IDXW'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        bus.in_ready   = in_ready;
        bus.out_valid  = (state_q == HOLD);
        bus.out_shares = slots_q;
        bus.share_idx  = idx_q;
        bus.sync_err   = sync_err_q;
    end
endmodule

// File: tb/tb_share_serial_collector.sv
// Randomised + directed bench: a queue-based share model predicts frames and per-cycle outputs; a monitor checks.
module tb_share_serial_collector;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    share_serial_collector_if #(.WIDTH(W), .NSHARES(N)) bus ();
    share_serial_collector_if #(.WIDTH(W), .NSHARES(N)) bus_nz ();

    share_serial_collector #(.WIDTH(W), .NSHARES(N), .ZERO_ON_CONSUME(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    share_serial_collector #(.WIDTH(W), .NSHARES(N), .ZERO_ON_CONSUME(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .bus(bus_nz)
    );

    typedef struct {
        int tag;
        logic rdy;
    } rdy_t;

    typedef struct {
        int tag;
        logic vld;
        logic [IW-1:0] idx;
        logic serr;
        logic [N*W-1:0] sh;
    } post_t;

    // Reference model: the shares of the frame being built, plus the frame currently held.
    logic [W-1:0]   partial[$];
    logic [N*W-1:0] frame_q[$];
    rdy_t           rdy_q[$];
    post_t          post_q[$];
    bit             hold_m = 1'b0;
    logic [N*W-1:0] hold_frame = '0;
    int             cons_m = 0;
    int             seen = 0;

    function automatic logic [N*W-1:0] pack_partial();
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < partial.size(); i++) r[i*W +: W] = partial[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit f, input logic [W-1:0] s, input bit o);
        bit    exp_rdy;
        bit    serr;
        rdy_t  re;
        post_t pe;
        @(posedge clk);
        #2;
        rst = r;
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_share = s;
        bus.out_ready = o;
        exp_rdy = !hold_m || o;
        serr = 1'b0;
        if (r) begin
            partial.delete();
            frame_q.delete();
            hold_m = 1'b0;
        end else begin
            if (hold_m && o) begin
                hold_m = 1'b0;
                cons_m++;
            end
            if (v && exp_rdy) begin
                if (f && partial.size() != 0) begin
                    partial.delete();
                    serr = 1'b1;
                end
                partial.push_back(s);
                if (partial.size() == N) begin
                    hold_frame = pack_partial();
                    frame_q.push_back(hold_frame);
                    partial.delete();
                    hold_m = 1'b1;
                end
            end
        end
        re.tag = cyc;
        re.rdy = exp_rdy;
        rdy_q.push_back(re);
        pe.tag  = cyc;
        pe.vld  = hold_m;
        pe.idx  = IW'(partial.size());
        pe.serr = serr;
        pe.sh   = hold_m ? hold_frame : pack_partial();
        post_q.push_back(pe);
    endtask

    task automatic drive_nz(input bit v, input bit f, input logic [W-1:0] s, input bit o);
        @(posedge clk);
        #2;
        bus_nz.in_valid = v;
        bus_nz.in_first = f;
        bus_nz.in_share = s;
        bus_nz.out_ready = o;
    endtask

    // Monitor: at each falling edge, in_ready reflects this cycle's inputs and the registered
    // outputs reflect the inputs of the previous cycle.
    always @(negedge clk) begin
        while (rdy_q.size() > 0 && rdy_q[0].tag == cyc) begin
            chk("in_ready", N*W'(bus.in_ready), N*W'(rdy_q[0].rdy));
            void'(rdy_q.pop_front());
        end
        while (post_q.size() > 0 && post_q[0].tag == cyc - 1) begin
            chk("out_valid", N*W'(bus.out_valid), N*W'(post_q[0].vld));
            chk("share_idx", N*W'(bus.share_idx), N*W'(post_q[0].idx));
            chk("sync_err", N*W'(bus.sync_err), N*W'(post_q[0].serr));
            chk("out_shares", bus.out_shares, post_q[0].sh);
            void'(post_q.pop_front());
        end
        if (!rst && bus.out_valid === 1'b1) begin
            if (frame_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame at cycle %0d: got unexpected frame %h, expected none", cyc, bus.out_shares);
            end else begin
                chk("frame", bus.out_shares, frame_q[0]);
                if (bus.out_ready) begin
                    void'(frame_q.pop_front());
                    seen++;
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_share = '0; bus.out_ready = 1'b0;
        bus_nz.in_valid = 1'b0; bus_nz.in_first = 1'b0; bus_nz.in_share = '0; bus_nz.out_ready = 1'b0;

        drive(1, 0, 0, 8'h00, 1);
        drive(1, 0, 0, 8'h00, 1);

        // Basic frame, consumed immediately.
        drive(0, 1, 1, 8'h11, 1);
        drive(0, 1, 0, 8'h22, 1);
        drive(0, 1, 0, 8'h33, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Backpressure: held frame, pending beat enters only on consume.
        drive(0, 1, 1, 8'h11, 1);
        drive(0, 1, 0, 8'h22, 1);
        drive(0, 1, 0, 8'h33, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 8'h44, 0);
        drive(0, 1, 0, 8'h44, 1);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 1, 0, 8'h45, 1);
        drive(0, 1, 0, 8'h46, 1);

        // Back-to-back streaming, three frames.
        for (int i = 0; i < 9; i++) drive(0, 1, (i % 3) == 0, W'(8'h60 + i), 1);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Resynchronisation.
        drive(0, 1, 1, 8'hAA, 1);
        drive(0, 1, 0, 8'hBB, 1);
        drive(0, 1, 1, 8'hCC, 1);
        drive(0, 1, 0, 8'hDD, 1);
        drive(0, 1, 0, 8'hEE, 1);
        drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Reset mid-frame, then a clean frame.
        drive(0, 1, 1, 8'h71, 1);
        drive(0, 1, 0, 8'h72, 1);
        drive(1, 0, 0, 8'h00, 1);
        drive(0, 1, 1, 8'h81, 1);
        drive(0, 1, 0, 8'h82, 1);
        drive(0, 1, 0, 8'h83, 1);
        drive(0, 0, 0, 8'h00, 1);

        // Randomised traffic with occasional resync markers and resets.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, W'($urandom), $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, 1);

        // Stale-data variant: slots are not cleared on consume.
        drive_nz(1, 1, 8'h11, 1);
        drive_nz(1, 0, 8'h22, 1);
        drive_nz(1, 0, 8'h33, 1);
        drive_nz(0, 0, 8'h00, 1);
        @(negedge clk);
        chk("nz_out_valid_hold", N*W'(bus_nz.out_valid), N*W'(1));
        chk("nz_frame", bus_nz.out_shares, 24'h332211);
        drive_nz(1, 1, 8'h55, 1);
        drive_nz(0, 0, 8'h00, 0);
        @(negedge clk);
        chk("nz_stale_slots", bus_nz.out_shares, 24'h332255);
        chk("nz_out_valid", N*W'(bus_nz.out_valid), N*W'(0));
        chk("nz_share_idx", N*W'(bus_nz.share_idx), N*W'(1));

        @(negedge clk);
        @(negedge clk);
        chk("frames_consumed", N*W'(seen), N*W'(cons_m));
        chk("pending_expectations", N*W'(post_q.size()), N*W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/share_serial_collector.md
Name: share_serial_collector

Overview:
- Time-sharing front end for the masked AES S-box datapath.
- Accepts one WIDTH-bit share per cycle over a valid/ready handshake and assembles NSHARES shares into one registered parallel frame.
- Holds the frame under a valid/ready handshake until the downstream S-box stage consumes it.
- Generalises the fixed 8-bit single-share register array: parametrised width and share count, reset, flow control, share indexing, resynchronisation and stale-share clearing.

Parameters:
- WIDTH, 8: bits per share.
- NSHARES, 3: shares per frame. Legal range ≥2; 3 is the second-order default.
- ZERO_ON_CONSUME, 1: 1 = every frame slot is zeroed when a frame is consumed; 0 = slots keep stale data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input share valid.
- in_first  in  1  marks the beat as share 0 of a new frame; sampled only on accepted beats.
- in_share  in  WIDTH  incoming share.
- in_ready  out  1  collector can accept a beat this cycle.
- out_valid  out  1  complete frame present.
- out_ready  in  1  downstream accepts the frame.
- out_shares  out  NSHARES*WIDTH  frame; share i occupies bits [i*WIDTH +: WIDTH].
- share_idx  out  clog2(NSHARES)  slot the next accepted beat is written to.
- sync_err  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- On reset: out_shares=0, share_idx=0, out_valid=0, sync_err=0, state COLLECT. Reset mid-frame or mid-hold discards all contents with no error pulse.
- All outputs are registered except in_ready, which is combinational from state and out_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- COLLECT state:
  - in_ready=1, out_valid=0.
  - On accept, in_share is written to slot share_idx and share_idx increments.
  - When the beat written is at share_idx=NSHARES-1: share_idx wraps to 0, next state HOLD, out_valid=1 from the next cycle. Latency from last share accepted to out_valid is 1 cycle.
- HOLD state:
  - out_valid=1; out_shares is stable until consumed.
  - in_ready=out_ready, so a beat is only accepted in the cycle the frame is consumed.
  - Consume with no accept: next state COLLECT, share_idx=0.
  - Consume with accept: the beat is written to slot 0, share_idx=1, next state COLLECT. This gives a sustained throughput of one frame per NSHARES cycles.
  - in_valid while out_ready=0: not accepted; the upstream must hold the beat.
- ZERO_ON_CONSUME=1: on consume, every slot is cleared to 0, except slot 0 when a simultaneous accept writes it. A new frame therefore never combines with shares from the previous frame.
- Resync:
  - Accepted beat with in_first=1 while share_idx≠0 in COLLECT: the partial frame is dropped. Slots 1..NSHARES-1 are zeroed if ZERO_ON_CONSUME=1.
  - The beat is stored in slot 0, share_idx=1, and sync_err=1 for exactly the next cycle.
  - in_first=1 at share_idx=0, or in_first=0 at any index: no error, normal write.
- sync_err is otherwise 0. It is never asserted because of a reset.
- No combinational path from in_share to out_shares. Each share passes through exactly one register.

Test Plan:
- WIDTH=8, NSHARES=3, out_ready=1; beats 0x11, 0x22, 0x33 on consecutive cycles, in_first on the first → out_valid=1 one cycle after 0x33, out_shares=0x332211, share_idx returns to 0.
- Backpressure: out_ready=0 for 5 cycles after the frame completes, in_valid=1 with 0x44 → in_ready=0, frame 0x332211 held stable. Raise out_ready → 0x44 lands in slot 0, share_idx=1; with ZERO_ON_CONSUME=1, out_shares=0x000044 next cycle.
- Back-to-back streaming: 9 consecutive beats, out_ready=1 → out_valid rises every 3rd cycle, no beat dropped, 3 frames in order.
- Resync: 0xAA (first), 0xBB, then 0xCC with in_first=1 → sync_err pulses one cycle, slot0=0xCC, slots1–2=0, share_idx=1; then 0xDD, 0xEE → frame 0xEEDDCC.
- Reset mid-frame: after 2 beats, assert rst for 1 cycle → all outputs zero, share_idx=0, sync_err=0; next 3 beats form a clean frame.
- ZERO_ON_CONSUME=0: consume 0x332211, then a single beat 0x55 → out_shares internal slots read 0x332255 while out_valid=0.
